sha256_msg_schedule: RTL



---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_msg_schedule_if.sv | 25 ++
 rtl/sha256_w_next.sv | 15 +
 rtl/sha256_msg_schedule.sv | 96 +++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, sigma functions, IV and round constants, schedule FSM states.
// No logic of its own; latency and backpressure are properties of the blocks that import it.
// Also imported by the compression block, so constants live here rather than in the schedule.
package sha256_pkg;

    localparam int WORDS = 64;
    localparam int WIN   = 16;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam word_t H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t S0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t S1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / W-word-out bundle of the message schedule.
// Block side is valid/ready; word side is done/w_ready (word moves when both high).
// slave = schedule view, master = block source plus round-logic consumer.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic [511:0] block_in;
    logic         block_valid;
    logic         block_ready;
    word_t        output_w;
    logic         done;
    logic         w_ready;
    logic [5:0]   w_index;
    logic         w_last;

    modport slave (
        input  block_in, block_valid, w_ready,
        output block_ready, output_w, done, w_index, w_last
    );

    modport master (
        output block_in, block_valid, w_ready,
        input  block_ready, output_w, done, w_index, w_last
    );
endinterface

// File: rtl/sha256_w_next.sv
// Next schedule word from the four sliding-window taps.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the result is written.
module sha256_w_next
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_new
);
    // Taps are W[t-16], W[t-15], W[t-7], W[t-2] relative to the word being built.
    assign w_new = s1(w14) + w9 + s0(w1) + w0;
endmodule

// File: rtl/sha256_msg_schedule.sv
// Expands one 512-bit block into W[0..63], one word per cycle on output_w.
// First word valid the cycle after acceptance; 65-cycle block period with w_ready high.
// w_ready low freezes window/count/output; block_ready only high in IDLE.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int WORDS = sha256_pkg::WORDS,
    parameter int WIN   = sha256_pkg::WIN
)
(
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_schedule_if.slave  bus
);

    state_t     state;
    state_t     state_nxt;
    word_t      window [WIN];
    logic [5:0] count;
    logic       load;
    logic       advance;
    logic       at_last;
    word_t      w_new;

    assign at_last = (count == 6'(WORDS - 1));

    sha256_w_next u_w_next (
        .w0    (window[0]),
        .w1    (window[1]),
        .w9    (window[9]),
        .w14   (window[14]),
        .w_new (w_new)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        load            = 1'b0;
        advance         = 1'b0;
        bus.block_ready = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE: begin
                bus.block_ready = 1'b1;
                if (bus.block_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.done = 1'b1;
                if (bus.w_ready) begin
                    // The last transfer leaves the window alone so W63 stays on output_w.
                    if (at_last) begin
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIN; i++) begin
                window[i] <= '0;
            end
            count <= '0;
        end else if (load) begin
            for (int i = 0; i < WIN; i++) begin
                window[i] <= bus.block_in[511 - 32*i -: 32];
            end
            count <= '0;
        end else if (advance) begin
            for (int i = 0; i < WIN - 1; i++) begin
                window[i] <= window[i + 1];
            end
            window[WIN - 1] <= w_new;
            count           <= count + 6'd1;
        end
    end

    assign bus.output_w = window[0];
    assign bus.w_index  = count;
    assign bus.w_last   = bus.done && at_last;

endmodule
